// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state encoding and default widths shared by the arbiter files
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_DM = 3'd2,
    S_DONE_IF = 3'd3,
    S_DONE_DM = 3'd4
  } state_e;
endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// mem_port_arbiter_sat_counter: up-counter that sticks at all-ones
module mem_port_arbiter_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access, data first
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_kill,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_ready,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_deny_cnt
);
  state_e            r_state, w_next;
  logic              r_killed, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic              w_idle, w_take_dm, w_take_if, w_deny;
  assign w_idle    = r_state == S_IDLE;
  assign w_take_dm = w_idle && i_dm_req;
  assign w_take_if = w_idle && !i_dm_req && i_if_req && !i_if_kill;
  assign w_deny    = w_idle && i_dm_req && i_if_req;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:    w_next = w_take_dm ? S_BUSY_DM : w_take_if ? S_BUSY_IF : S_IDLE;
      S_BUSY_IF: w_next = i_mem_ack ? S_DONE_IF : S_BUSY_IF;
      S_BUSY_DM: w_next = i_mem_ack ? S_DONE_DM : S_BUSY_DM;
      default:   w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_mem_req  = (r_state == S_BUSY_IF) || (r_state == S_BUSY_DM);
    o_if_ready = (r_state == S_DONE_IF) && !r_killed;
    o_dm_ready = r_state == S_DONE_DM;
  end
  // A kill coinciding with the acknowledge still discards that fetch's data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_killed    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_killed <= (r_state == S_DONE_IF) ? 1'b0 :
                  (r_state == S_BUSY_IF && i_if_kill) ? 1'b1 : r_killed;
      if (w_take_dm) begin
        r_mem_we    <= i_dm_we;
        r_mem_addr  <= i_dm_addr;
        r_mem_wdata <= i_dm_wdata;
      end else if (w_take_if) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= i_if_addr;
      end
      if (r_state == S_BUSY_IF && i_mem_ack && !r_killed && !i_if_kill) r_if_rdata <= i_mem_rdata;
      if (r_state == S_BUSY_DM && i_mem_ack) r_dm_rdata <= i_mem_rdata;
    end
  end
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  mem_port_arbiter_sat_counter #(.W(CNT_W)) u_deny (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (w_deny),
    .o_cnt  (o_deny_cnt)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios, then random requesters against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, CW = 4;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic          if_ready, dm_ready, mem_req, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] deny_cnt;
  int            checks = 0, errors = 0;
  logic [31:0]   mem_arr [logic [31:0]];
  logic [31:0]   ref_mem [logic [31:0]];
  int            w, if_wait, dm_wait, exp_deny;
  logic          in_txn, t_dm, tk, a_dm, a_if, a_kill, f_done, d_done, kp;
  logic [31:0]   t_addr, a_data, exp_if;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
    .o_if_ready(if_ready), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_deny_cnt(deny_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=%h required=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  initial begin
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_ready", dm_ready, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_deny", deny_cnt, 0);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    // fetch with two memory wait cycles
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check("f_req", mem_req, 1); check("f_addr", mem_addr, 32'h100); check("f_we", mem_we, 0);
    @(negedge clk);
    check("f_wait", mem_req, 1);
    @(negedge clk);
    check("f_ready_early", if_ready, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    mem_ack = 1'b0;
    check("f_ready", if_ready, 1); check("f_rdata", if_rdata, 32'h0050_0093); check("f_done_req", mem_req, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("f_pulse", if_ready, 0);
    // simultaneous store and fetch: store wins, fetch follows
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("s_we", mem_we, 1); check("s_addr", mem_addr, 32'h2000);
    check("s_wdata", mem_wdata, 32'hDEAD_BEEF); check("s_deny", deny_cnt, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("s_ready", dm_ready, 1); check("s_if_wait", if_ready, 0);
    dm_req = 1'b0;
    @(negedge clk);
    check("s_idle", mem_req, 0); check("s_deny_hold", deny_cnt, 1);
    // the fetch is killed while in flight
    @(negedge clk);
    check("k_addr", mem_addr, 32'h104); check("k_we", mem_we, 0);
    if_kill = 1'b1;
    @(negedge clk);
    if_kill = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack = 1'b0;
    check("k_ready", if_ready, 0); check("k_rdata", if_rdata, 32'h0050_0093);
    if_addr = 32'h200;
    @(negedge clk);
    check("k_idle", mem_req, 0);
    @(negedge clk);
    check("n_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    mem_ack = 1'b0;
    check("n_ready", if_ready, 1); check("n_rdata", if_rdata, 32'h13);
    if_req = 1'b0;
    // reset during a load abandons it
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2004;
    @(negedge clk);
    check("r_busy", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("r_drop", mem_req, 0); check("r_deny", deny_cnt, 0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    check("r_ready", dm_ready, 0); check("r_req", mem_req, 0); check("r_rdata", dm_rdata, 0);
    @(negedge clk);
    check("r_ready2", dm_ready, 0); check("r_req2", mem_req, 0);
    // random traffic against the transaction-level model
    w = 0; if_wait = 0; dm_wait = 0; exp_deny = 0; exp_if = 32'h0;
    in_txn = 0; t_dm = 0; tk = 0; a_dm = 0; a_if = 0; a_kill = 0; t_addr = '0; a_data = '0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      f_done = a_if && !a_kill;
      d_done = a_dm;
      check("if_ready", if_ready, f_done);
      check("dm_ready", dm_ready, d_done);
      if (f_done) exp_if = a_data;
      check("if_rdata", if_rdata, exp_if);
      if (d_done && !dm_we)
        check("dm_rdata", dm_rdata, ref_mem.exists(dm_addr) ? ref_mem[dm_addr] : rom(dm_addr));
      if (d_done && dm_we) ref_mem[dm_addr] = dm_wdata;
      a_if = 0; a_dm = 0;
      if (mem_req && !in_txn) begin
        in_txn = 1; w = $urandom_range(0, 3); t_addr = mem_addr; tk = 0;
        t_dm = mem_addr >= 32'h2000;
        if (t_dm) begin
          check("dm_addr", mem_addr, dm_addr);
          check("dm_we", mem_we, dm_we);
          if (dm_we) check("dm_wdata", mem_wdata, dm_wdata);
          if (if_req && exp_deny != 15) exp_deny++;
        end else begin
          check("if_prio", dm_req, 0);
          check("if_addr", mem_addr, if_addr);
          check("if_we", mem_we, 0);
        end
      end else if (mem_req) check("addr_stable", mem_addr, t_addr);
      check("deny", deny_cnt, exp_deny);
      kp = if_kill;
      if_kill = 1'b0;
      if (f_done || kp) begin
        if_addr = 32'($urandom_range(0, 1023)) << 2;
        if_req = f_done ? ($urandom_range(0, 1) == 1) : 1'b1;
        if_wait = 0;
      end else if (!if_req) begin
        if (($urandom_range(0, 2) == 0)) begin
          if_req = 1'b1;
          if_addr = 32'($urandom_range(0, 1023)) << 2;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        if_kill = 1'b1;
        if (mem_req && !t_dm) tk = 1;
      end
      if (if_req) if_wait++;
      if (if_wait > 60) begin
        check("if_timeout", if_wait, 0);
        if_wait = 0;
      end
      if (d_done) begin
        dm_req = ($urandom_range(0, 3) == 0);
        dm_wait = 0;
      end else if (!dm_req && $urandom_range(0, 2) == 0) dm_req = 1'b1;
      if (dm_req && (d_done || dm_wait == 0)) begin
        dm_we = $urandom_range(0, 1) == 1;
        dm_addr = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
        dm_wdata = $urandom;
      end
      if (dm_req) dm_wait++;
      if (dm_wait > 60) begin
        check("dm_timeout", dm_wait, 0);
        dm_wait = 1;
      end
      if (mem_req && in_txn) begin
        if (w == 0) begin
          a_data = mem_we ? $urandom : (mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : rom(mem_addr));
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          mem_ack = 1'b1; mem_rdata = a_data;
          a_dm = t_dm; a_if = !t_dm; a_kill = tk; in_txn = 0;
        end else begin
          w--;
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ack = $urandom_range(0, 7) == 0;
        mem_rdata = $urandom;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the instruction-fetch stage and the data-memory (MEM) stage of the pipelined RV32I CPU. The block grants one requester at a time, with data access over fetch. It runs a variable-latency request/acknowledge handshake toward memory and returns read data with a one-cycle ready pulse. It sits between the IF/MEM stages and the memory model, and its ready signals gate the pipeline-register enables.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, width of the saturating fetch-denial counter

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request, held until if_ready
- if_addr  input  ADDR_W  fetch address (PC)
- if_kill  input  1  pulse; discard the in-flight fetch (branch/jump taken)
- if_ready  output  1  one-cycle pulse; if_rdata valid
- if_rdata  output  DATA_W  fetched instruction
- dm_req  input  1  data request, held until dm_ready
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_ready  output  1  one-cycle pulse; access complete, dm_rdata valid for loads
- dm_rdata  output  DATA_W  load data
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_ack  input  1  memory completion pulse; mem_rdata valid in the same cycle
- mem_rdata  input  DATA_W  memory read data
- deny_cnt  output  CNT_W  count of cycles in which fetch lost arbitration (saturating)

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM.
- IDLE
  - dm_req=1 → latch dm_addr/dm_we/dm_wdata, go to BUSY_DM.
  - else if_req=1 and if_kill=0 → latch if_addr, go to BUSY_IF.
  - Otherwise stay in IDLE.
- BUSY_x
  - mem_req=1; mem_addr, mem_we and mem_wdata come from the latched registers and stay stable.
  - On mem_ack: register mem_rdata into x_rdata and go to DONE_x.
- DONE_x
  - x_ready=1 for exactly this cycle, then return to IDLE.
  - Requests are not sampled in DONE states, so each requester has one edge to drop or change its request.
- Fetch kill
  - if_kill in BUSY_IF sets the killed flag.
  - In DONE_IF with killed=1, if_ready stays 0 and if_rdata is not updated. Clear the flag when leaving DONE_IF.
  - if_kill in DONE_IF does not suppress the ready pulse already issued.
  - if_kill in IDLE blocks acceptance of if_req that cycle.
  - if_kill in any other state is ignored.
- In fetch transactions mem_we=0 and mem_wdata is don't-care; drive the latched value.
- mem_ack outside BUSY states is ignored (stray or post-reset acknowledge).
- deny_cnt increments in IDLE when if_req=1 and dm_req=1. It saturates at 2^CNT_W−1 and never wraps.
- Data priority is absolute. Starvation of fetch is impossible, because the MEM stage stalls until dm_ready and IF is then served.

## Timing
- Reset values, asynchronous on reset_n low:
  - state=IDLE, killed=0, mem_req=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0.
  - if_rdata=0, dm_rdata=0, deny_cnt=0.
- Reset mid-transaction abandons it: mem_req drops immediately and no ready pulse is issued.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.
- Request sampled in IDLE at edge 0.
  - mem_req high in cycle 1.
  - Earliest mem_ack in cycle 1; ready pulse in cycle 2.
  - Latency = 2 + memory wait cycles.
- Minimum issue interval per transaction is 3 cycles (IDLE, BUSY, DONE).
- x_rdata holds its value until the next completed transaction of the same requester.

## Structure
- Shared include (cpu_defs) holds:
  - the state encodings (IDLE=0, BUSY_IF=1, BUSY_DM=2, DONE_IF=3, DONE_DM=4, 3-bit);
  - the default widths ADDR_W/DATA_W.
- One sub-module is natural: sat_counter (parameterised width, increment enable, async active-low clear) for deny_cnt. Everything else is a single FSM.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, mem_ack after 2 wait cycles with mem_rdata=0x00500093 → if_ready pulses in cycle 4, if_rdata=0x00500093, mem_we=0.
- Simultaneous: if_req=dm_req=1, dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF → store issued first with mem_we=1; deny_cnt=1; fetch is issued in the IDLE following DONE_DM.
- Kill: fetch to 0x104 in BUSY_IF, if_kill pulse, then mem_ack → no if_ready, if_rdata unchanged; a next fetch to 0x200 completes normally.
- Saturation: CNT_W=4, hold both requests across 20 data transactions → deny_cnt reaches 15 and stays at 15.
- Reset mid-op: reset_n low during BUSY_DM, then mem_ack after release → mem_req=0 immediately, no dm_ready, FSM in IDLE, ack ignored.
- Zero-wait memory: mem_ack in the same cycle as mem_req → ready exactly 2 cycles after acceptance; back-to-back loads every 3 cycles.
